// File: rtl/pwm_sar_pkg.sv
// rtl/pwm_sar_pkg.sv - shared types and constants for the PWM SAR loop
package pwm_sar_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} settle_state_t;

  localparam int MAX_SETTLE_PERIODS = 255;

  function automatic int period_len(input int width);
    return 2 ** width;
  endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// rtl/pwm_period_gen.sv - free-running PWM period counter with registered pwm output
module pwm_period_gen
  import pwm_sar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] duty_next_i,
  output logic             tick_o,
  output logic             pwm_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(period_len(WIDTH) - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  // pwm is computed from next-cycle count and duty so the flop output lines up with cnt
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    pwm_d = (cnt_d < duty_next_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_dac_settle_sequencer.sv
// rtl/pwm_dac_settle_sequencer.sv - loads SAR trial codes at period boundaries and pulses sample_en once settled
module pwm_dac_settle_sequencer
  import pwm_sar_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             sample_en,
  output logic [WIDTH-1:0] applied_duty,
  output logic             settling
);

  if (SETTLE_PERIODS < 1 || SETTLE_PERIODS > MAX_SETTLE_PERIODS) begin : g_bad_settle
    $error("SETTLE_PERIODS must be within 1..MAX_SETTLE_PERIODS");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_PERIODS - 1);

  settle_state_t    state_q, state_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0] applied_q, applied_d;
  logic             tick;

  pwm_period_gen #(.WIDTH(WIDTH)) u_period_gen (
    .clk        (clk),
    .reset      (reset),
    .duty_next_i(applied_d),
    .tick_o     (tick),
    .pwm_o      (pwm_out)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    applied_d    = applied_q;
    sample_en    = 1'b0;
    settling     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run && tick) begin
          applied_d    = duty_in;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        settling = 1'b1;
        if (!run) begin
          state_d = IDLE;
        end else if (tick) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
          else settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      applied_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      applied_q    <= applied_d;
    end
  end

  assign applied_duty = applied_q;

endmodule

// File: tb/tb_pwm_dac_settle_sequencer.sv
// tb/tb_pwm_dac_settle_sequencer.sv - directed self-checking bench for pwm_dac_settle_sequencer
module tb_pwm_dac_settle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] duty_in = 8'h00;
  logic       pwm_out;
  logic       sample_en;
  logic [7:0] applied_duty;
  logic       settling;

  int checks = 0;
  int errors = 0;

  logic [7:0] tb_cnt = 8'h00;

  pwm_dac_settle_sequencer #(.WIDTH(8), .SETTLE_PERIODS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .duty_in     (duty_in),
    .pwm_out     (pwm_out),
    .sample_en   (sample_en),
    .applied_duty(applied_duty),
    .settling    (settling)
  );

  always #5 clk = ~clk;

  // reference period counter; at a negedge it equals the DUT count of that cycle
  always @(posedge clk) begin
    if (reset) tb_cnt <= 8'h00;
    else tb_cnt <= tb_cnt + 8'd1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tb_cnt != 8'hFF && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tb_cnt != 8'hFF) begin
      errors++;
      $display("FAIL wait_tick: tick not seen, cnt=%0d required 255", tb_cnt);
    end
  endtask

  task automatic test_reset();
    int bad_pwm, bad_se, bad_ad, bad_st;
    run = 1'b0;
    duty_in = 8'h5A;
    do_reset();
    bad_pwm = 0; bad_se = 0; bad_ad = 0; bad_st = 0;
    for (int k = 0; k < 1000; k++) begin
      if (pwm_out !== 1'b0) bad_pwm++;
      if (sample_en !== 1'b0) bad_se++;
      if (applied_duty !== 8'h00) bad_ad++;
      if (settling !== 1'b0) bad_st++;
      @(negedge clk);
    end
    checks++; if (bad_pwm != 0) begin errors++; $display("FAIL reset_pwm: %0d nonzero cycles, required 0", bad_pwm); end
    checks++; if (bad_se != 0) begin errors++; $display("FAIL reset_sample_en: %0d pulses, required 0", bad_se); end
    checks++; if (bad_ad != 0) begin errors++; $display("FAIL reset_applied: %0d nonzero cycles, required 0", bad_ad); end
    checks++; if (bad_st != 0) begin errors++; $display("FAIL reset_settling: %0d high cycles, required 0", bad_st); end
  endtask

  task automatic test_basic();
    int highs, bad_pwm, bad_st, first_se, n_se;
    logic [7:0] ad_k1;
    do_reset();
    run = 1'b1;
    duty_in = 8'h80;
    wait_tick();
    highs = 0; bad_pwm = 0; bad_st = 0; first_se = -1; n_se = 0; ad_k1 = 8'h00;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (k == 1) ad_k1 = applied_duty;
      if (k <= 256) begin
        if (pwm_out === 1'b1) highs++;
        if (pwm_out !== (tb_cnt < 8'h80)) bad_pwm++;
      end
      if (k <= 1024 && settling !== 1'b1) bad_st++;
      if (sample_en === 1'b1) begin
        n_se++;
        if (first_se < 0) first_se = k;
      end
    end
    checks++; if (ad_k1 !== 8'h80) begin errors++; $display("FAIL basic_applied: got %h required 80", ad_k1); end
    checks++; if (highs != 128) begin errors++; $display("FAIL basic_pwm_highs: got %0d required 128", highs); end
    checks++; if (bad_pwm != 0) begin errors++; $display("FAIL basic_pwm_shape: %0d wrong cycles, required 0", bad_pwm); end
    checks++; if (bad_st != 0) begin errors++; $display("FAIL basic_settling: %0d low cycles, required 0", bad_st); end
    checks++; if (first_se != 1025) begin errors++; $display("FAIL basic_pulse_time: got %0d required 1025", first_se); end
    checks++; if (n_se != 1) begin errors++; $display("FAIL basic_pulse_count: got %0d required 1", n_se); end
  endtask

  task automatic test_duty_hold();
    int bad_a, bad_b, bad_ad;
    logic [7:0] ad_1281;
    do_reset();
    run = 1'b1;
    duty_in = 8'h40;
    wait_tick();
    bad_a = 0; bad_b = 0; bad_ad = 0; ad_1281 = 8'h00;
    for (int k = 1; k <= 1536; k++) begin
      @(negedge clk);
      if (k == 300) duty_in = 8'hC0;
      if (k <= 1280) begin
        if (pwm_out !== (tb_cnt < 8'h40)) bad_a++;
        if (applied_duty !== 8'h40) bad_ad++;
      end else begin
        if (pwm_out !== (tb_cnt < 8'hC0)) bad_b++;
      end
      if (k == 1281) ad_1281 = applied_duty;
    end
    checks++; if (bad_ad != 0) begin errors++; $display("FAIL hold_applied: %0d cycles not 40", bad_ad); end
    checks++; if (bad_a != 0) begin errors++; $display("FAIL hold_pwm_old: %0d wrong cycles, required 0", bad_a); end
    checks++; if (ad_1281 !== 8'hC0) begin errors++; $display("FAIL hold_next_load: got %h required c0", ad_1281); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL hold_pwm_new: %0d wrong cycles, required 0", bad_b); end
  endtask

  task automatic test_boundary();
    int highs, lows, bad_low;
    do_reset();
    run = 1'b1;
    duty_in = 8'h00;
    wait_tick();
    highs = 0;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL bound_zero: %0d high cycles, required 0", highs); end
    do_reset();
    duty_in = 8'hFF;
    wait_tick();
    lows = 0; bad_low = 0;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (pwm_out !== 1'b1) begin
        lows++;
        if (tb_cnt != 8'hFF) bad_low++;
      end
    end
    checks++; if (lows != 2) begin errors++; $display("FAIL bound_full_lows: got %0d required 2", lows); end
    checks++; if (bad_low != 0) begin errors++; $display("FAIL bound_full_pos: %0d lows off cnt 255", bad_low); end
  endtask

  task automatic test_run_drop();
    int n_se, first_se, n;
    do_reset();
    run = 1'b1;
    duty_in = 8'h33;
    wait_tick();
    repeat (500) @(negedge clk);
    checks++; if (settling !== 1'b1) begin errors++; $display("FAIL drop_pre_settling: got %b required 1", settling); end
    run = 1'b0;
    @(negedge clk);
    checks++; if (settling !== 1'b0) begin errors++; $display("FAIL drop_idle: settling %b required 0", settling); end
    checks++; if (applied_duty !== 8'h33) begin errors++; $display("FAIL drop_applied: got %h required 33", applied_duty); end
    n_se = 0;
    for (int k = 0; k < 2000; k++) begin
      if (sample_en !== 1'b0) n_se++;
      @(negedge clk);
    end
    checks++; if (n_se != 0) begin errors++; $display("FAIL drop_no_pulse: got %0d required 0", n_se); end
    n = 0;
    while (tb_cnt != 8'd100 && n < 300) begin @(negedge clk); n++; end
    run = 1'b1;
    duty_in = 8'h55;
    wait_tick();
    first_se = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (sample_en === 1'b1 && first_se < 0) first_se = k;
    end
    checks++; if (first_se != 1025) begin errors++; $display("FAIL rerun_pulse_time: got %0d required 1025", first_se); end
    checks++; if (applied_duty !== 8'h55) begin errors++; $display("FAIL rerun_applied: got %h required 55", applied_duty); end
  endtask

  task automatic test_closed_loop();
    logic [7:0] result, trial;
    int bitpos, npulse, last_t, bad_gap;
    do_reset();
    result = 8'h00;
    bitpos = 7;
    trial = 8'h80;
    duty_in = trial;
    run = 1'b1;
    npulse = 0; last_t = 0; bad_gap = 0;
    for (int t = 0; t < 12000 && npulse < 8; t++) begin
      @(negedge clk);
      if (sample_en === 1'b1) begin
        if (npulse > 0 && (t - last_t) != 1280) bad_gap++;
        last_t = t;
        npulse++;
        if (trial <= 8'hA5) result = trial;
        bitpos--;
        if (bitpos >= 0) trial = result | (8'h01 << bitpos);
        duty_in = trial;
      end
    end
    run = 1'b0;
    checks++; if (npulse != 8) begin errors++; $display("FAIL loop_pulses: got %0d required 8", npulse); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL loop_spacing: %0d gaps not 1280", bad_gap); end
    checks++; if (result !== 8'hA5) begin errors++; $display("FAIL loop_result: got %h required a5", result); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    duty_in = 8'hF0;
    wait_tick();
    repeat (700) @(negedge clk);
    checks++; if (settling !== 1'b1 || applied_duty !== 8'hF0) begin
      errors++; $display("FAIL midrst_pre: settling %b applied %h required 1 f0", settling, applied_duty);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pwm_out !== 1'b0 || sample_en !== 1'b0 || applied_duty !== 8'h00 || settling !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: pwm %b se %b applied %h settling %b required 0 0 00 0",
               pwm_out, sample_en, applied_duty, settling);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_hold();
    test_boundary();
    test_run_drop();
    test_closed_loop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_dac_settle_sequencer.md
Name: pwm_dac_settle_sequencer

Overview:
- Upstream stage of the PWM successive-approximation loop.
- Turns the SAR trial code (current_duty_cycle) into a PWM waveform for the external RC filter and comparator.
- Applies new codes only at PWM period boundaries and waits a programmable number of full periods for the RC node to settle.
- Then issues a one-cycle sample_en pulse, which drives the SAR controller's enable so each comparator decision uses a settled reference.

Parameters:
WIDTH, 8, duty/code width; PWM period = 2^WIDTH clocks
SETTLE_PERIODS, 4, full PWM periods to wait after a code load before sampling; legal range 1..255

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = sequencer active, 0 = hold and stop issuing samples
duty_in  input  WIDTH  trial code from the SAR controller (current_duty_cycle)
pwm_out  output  1  PWM drive to the RC filter, registered
sample_en  output  1  one-cycle pulse: RC node settled, comparator valid; connects to SAR enable
applied_duty  output  WIDTH  code currently being generated on pwm_out
settling  output  1  high while in SETTLE state

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: period counter 0, applied_duty 0, pwm_out 0, sample_en 0, settling 0, settle counter 0, state IDLE. Reset wins over every other event, including mid-SETTLE.
- Period counter cnt runs 0..2^WIDTH-1 every cycle, then wraps to 0. It runs regardless of run. tick = (cnt == 2^WIDTH-1).
- pwm_out comes from a flop. In the cycle where cnt == c, pwm_out == (c < applied_duty).
  - applied_duty = 0 gives a constant 0.
  - applied_duty = 2^WIDTH-1 gives high for 255 of every 256 clocks (WIDTH=8).
- duty_in is sampled only at a load tick. Changes at any other time are ignored.
- A new applied_duty takes effect from cnt = 0 of the following period, so there are no partial periods.
- FSM states are IDLE, SETTLE and SAMPLE.
  - IDLE: if run && tick, then applied_duty <= duty_in, settle_cnt <= 0, go to SETTLE. Otherwise stay.
  - SETTLE: settling = 1.
    - If run = 0, go to IDLE immediately: no pulse, applied_duty held.
    - On tick, if settle_cnt == SETTLE_PERIODS-1, go to SAMPLE; otherwise settle_cnt++.
  - SAMPLE: sample_en = 1 (Moore output, exactly one cycle, coincides with cnt == 0). Next state is IDLE unconditionally.
- Step timing:
  - Load tick at cycle T.
  - sample_en high at cycle T + SETTLE_PERIODS*2^WIDTH + 1.
  - Next load at the following tick, i.e. 2^WIDTH-1 cycles after the pulse.
  - One SAR step takes (SETTLE_PERIODS+1)*2^WIDTH clocks.
- The SAR updates duty_in within a few cycles of sample_en. The next load is always at least 2^WIDTH-1 cycles later, so there is no race.
- run rising mid-period: the first load occurs at the next tick.
- run falling in SAMPLE has no effect on that pulse. IDLE then waits for run.
- sample_en is never asserted while run = 0 except in that SAMPLE cycle. Two pulses are never closer than (SETTLE_PERIODS+1)*2^WIDTH clocks.

Decomposition:
- Shared package pwm_sar_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} settle_state_t
  - localparam MAX_SETTLE_PERIODS = 255
  - function period_len(WIDTH) = 2**WIDTH
- One sub-module, pwm_period_gen (cnt, tick, registered pwm_out from applied_duty). The FSM and load register stay in the top.
- Elaboration-time assertion rejects a SETTLE_PERIODS value outside 1..MAX_SETTLE_PERIODS.

Test Plan:
1. Reset held 3 cycles, then released with run = 0 -> pwm_out, sample_en, applied_duty all 0 for 1000 cycles. cnt wraps every 256 clocks.
2. run = 1, duty_in = 8'h80, SETTLE_PERIODS = 4 ->
   - applied_duty = 8'h80 after the first tick.
   - pwm_out high for exactly 128 of every 256 clocks.
   - a single sample_en at load tick + 1025 cycles, with settling high throughout the wait.
3. duty_in toggled 8'h40 -> 8'hC0 mid-SETTLE -> applied_duty stays 8'h40 until the next load tick. No partial period appears on pwm_out.
4. Boundary codes: duty_in = 8'h00 -> pwm_out constant 0. duty_in = 8'hFF -> pwm_out low exactly once per 256 clocks, at cnt = 255.
5. run dropped during SETTLE -> no sample_en, FSM in IDLE. Re-asserting run loads at the next tick; the pulse arrives 1025 cycles later.
6. Closed loop with SuccessiveFSM and a comparator model (Vin = code 8'hA5) -> 8 sample pulses spaced 1280 clocks apart; captured result = 8'hA5. Reset asserted mid-conversion -> all outputs return to reset values on the next edge.
